mux21_arb: RTL and testbench
============================

MUX21_ARB -- requirements
Module: mux21_arb

Interface
REQ-001 Parameter: WIDTH, default 8, data width of each channel and the output.
REQ-002 Parameter: PKT_LOCK, default 1; 1 holds the grant until a last beat, 0 arbitrates every beat.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 a0_data  input  WIDTH  channel 0 data.
REQ-006 a0_valid  input  1  channel 0 beat valid.
REQ-007 a0_last  input  1  channel 0 final beat of packet.
REQ-008 a0_ready  output  1  channel 0 beat accepted this cycle when high with a0_valid.
REQ-009 a1_data, a1_valid, a1_last, a1_ready: same as REQ-005..REQ-008 for channel 1.
REQ-010 y_data  output  WIDTH  registered selected data.
REQ-011 y_valid  output  1  output beat valid.
REQ-012 y_last  output  1  registered last flag of the output beat.
REQ-013 y_src  output  1  channel that produced the output beat (0 or 1).
REQ-014 y_ready  input  1  downstream accepts the output beat.

Function
REQ-015 A beat transfers on any interface when valid and ready are both high at a rising clk edge.
REQ-016 Output register load enable: ld = !y_valid | y_ready; y_ready reaches aN_ready combinationally.
REQ-017 Latency: an accepted input beat appears on y_* in the next cycle; full throughput is one beat per cycle.
REQ-018 States: IDLE, LOCK0, LOCK1; a last_grant register holds the channel of the most recently accepted beat.
REQ-019 IDLE grant: one valid channel wins alone; with both valid, the channel != last_grant wins (round-robin).
REQ-020 LOCKn grant: channel n only; the other channel's ready stays 0 regardless of its valid.
REQ-021 aN_ready = ld & (grant == N); at most one aN_ready is high in any cycle.
REQ-022 On acceptance from channel n: y_data/y_last <= an_data/an_last, y_src <= n, y_valid <= 1, last_grant <= n.
REQ-023 On ld with no accepted input: y_valid <= 0; y_data, y_last and y_src hold.
REQ-024 With y_valid=1 and y_ready=0: all y_* hold stable and both aN_ready are 0.
REQ-025 Transitions (PKT_LOCK=1): IDLE -> LOCKn on accepted non-last beat from n; LOCKn -> IDLE on accepted last beat from n; otherwise hold state.
REQ-026 A single-beat packet (last=1 on the first beat) leaves the FSM in IDLE.
REQ-027 PKT_LOCK=0: the FSM stays in IDLE, the last flags are only passed through, and arbitration runs every beat.
REQ-028 A locked channel dropping valid mid-packet keeps the lock; the other channel waits.

Reset
REQ-029 rst_n low asynchronously forces: state=IDLE, last_grant=1, y_valid=0, y_data=0, y_last=0, y_src=0.
REQ-030 While rst_n is low, a0_ready and a1_ready are 0.
REQ-031 Reset mid-packet discards the lock and any held output beat; after release, channel 0 wins the first contention.
REQ-032 Reset release is synchronous to clk in effect; the first acceptance can occur at the first edge after deassertion.

Verification
REQ-033 Reset, then a0_valid=a1_valid=1 single-beat (last=1), y_ready=1 -> y_src sequence 0,1,0,1, one beat per cycle.
REQ-034 a0 sends 3-beat packet 0x11,0x22,0x33 (last on 0x33) with a1 valid throughout -> y_data 0x11,0x22,0x33 with y_src=0, then a1 data with y_src=1.
REQ-035 y_ready=0 for 4 cycles with y_valid=1, y_data=0x5A -> y_* stable, a0_ready=a1_ready=0; y_ready=1 -> next beat follows one cycle later.
REQ-036 LOCK1 after a non-last beat, a1_valid drops 3 cycles while a0_valid=1 -> a0_ready stays 0 and y_valid=0; a1 resumes with last -> IDLE, then a0 granted.
REQ-037 rst_n pulsed low in LOCK0 with y_valid=1 -> y_valid=0 immediately; after release, both valid -> channel 0 granted first.
REQ-038 PKT_LOCK=0, both channels stream with last=0 -> y_src alternates 0,1,0,1 every cycle.

Source files
------------

// File: rtl/mux21_arb.sv
// Two-channel to one-output arbiter with optional packet lock and a registered output stage.
// Latency: one cycle from input acceptance to y_*; one beat per cycle sustained throughput.
// Backpressure: y_ready reaches the granted channel's ready combinationally through the load enable.
module mux21_arb #(
  parameter int WIDTH    = 8,
  parameter bit PKT_LOCK = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a0_data,
  input  logic             a0_valid,
  input  logic             a0_last,
  output logic             a0_ready,
  input  logic [WIDTH-1:0] a1_data,
  input  logic             a1_valid,
  input  logic             a1_last,
  output logic             a1_ready,
  output logic [WIDTH-1:0] y_data,
  output logic             y_valid,
  output logic             y_last,
  output logic             y_src,
  input  logic             y_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] y_data_q, y_data_d;
  logic             y_valid_q, y_valid_d;
  logic             y_last_q, y_last_d;
  logic             y_src_q, y_src_d;

  logic             ld;
  logic             grant;
  logic             acc;
  logic             sel_last;
  logic [WIDTH-1:0] sel_data;

  // Arbitration: lock owner wins outright, otherwise a lone requester wins, otherwise round-robin.
  always_comb begin
    ld    = ~y_valid_q | y_ready;
    grant = ~last_grant_q;
    case (state_q)
      LOCK0:   grant = 1'b0;
      LOCK1:   grant = 1'b1;
      default: begin
        if (a0_valid & ~a1_valid) begin
          grant = 1'b0;
        end else if (a1_valid & ~a0_valid) begin
          grant = 1'b1;
        end else begin
          grant = ~last_grant_q;
        end
      end
    endcase
    // Readies are held low during reset so nothing is consumed while the output stage is cleared.
    a0_ready = rst_n & ld & ~grant;
    a1_ready = rst_n & ld & grant;
    acc      = (a0_valid & a0_ready) | (a1_valid & a1_ready);
    sel_data = grant ? a1_data : a0_data;
    sel_last = grant ? a1_last : a0_last;
  end

  // Next-state for the output register, grant history and packet-lock FSM.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    y_data_d     = y_data_q;
    y_valid_d    = y_valid_q;
    y_last_d     = y_last_q;
    y_src_d      = y_src_q;
    if (acc) begin
      y_data_d     = sel_data;
      y_last_d     = sel_last;
      y_src_d      = grant;
      y_valid_d    = 1'b1;
      last_grant_d = grant;
      if (PKT_LOCK) begin
        case (state_q)
          IDLE: begin
            if (!sel_last) begin
              state_d = grant ? LOCK1 : LOCK0;
            end
          end
          LOCK0, LOCK1: begin
            if (sel_last) begin
              state_d = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end else if (ld) begin
      // Output slot drained with nothing to replace it; payload fields keep their last value.
      y_valid_d = 1'b0;
    end
  end

  // State registers; reset favours channel 0 in the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      y_data_q     <= '0;
      y_valid_q    <= 1'b0;
      y_last_q     <= 1'b0;
      y_src_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      y_data_q     <= y_data_d;
      y_valid_q    <= y_valid_d;
      y_last_q     <= y_last_d;
      y_src_q      <= y_src_d;
    end
  end

  assign y_data  = y_data_q;
  assign y_valid = y_valid_q;
  assign y_last  = y_last_q;
  assign y_src   = y_src_q;

endmodule

// File: tb/tb_mux21_arb.sv
// Scoreboard bench for mux21_arb: a packet-level reference model predicts grants and output beats,
// and a separate monitor pops expected beats whenever the output handshakes.
// A second instance with packet lock disabled is checked for per-beat alternation.
module tb_mux21_arb;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       s;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a0_data, a1_data;
  logic       a0_valid, a0_last, a1_valid, a1_last;
  logic       a0_ready, a1_ready;
  logic [7:0] y_data;
  logic       y_valid, y_last, y_src;
  logic       y_ready;
  logic       b0_ready, b1_ready;
  logic [7:0] y1_data;
  logic       y1_valid, y1_last, y1_src;

  int checks   = 0;
  int failures = 0;

  // Reference model state: packet owner (-1 = none), last winner, and whether an output beat is held.
  int    owner;
  int    prev_src;
  bit    mvalid;
  beat_t sb[$];

  always #5 clk = ~clk;

  mux21_arb #(.WIDTH(8), .PKT_LOCK(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .a0_data(a0_data), .a0_valid(a0_valid), .a0_last(a0_last), .a0_ready(a0_ready),
    .a1_data(a1_data), .a1_valid(a1_valid), .a1_last(a1_last), .a1_ready(a1_ready),
    .y_data(y_data), .y_valid(y_valid), .y_last(y_last), .y_src(y_src), .y_ready(y_ready)
  );

  mux21_arb #(.WIDTH(8), .PKT_LOCK(1'b0)) u_nolock (
    .clk(clk), .rst_n(rst_n),
    .a0_data(a0_data), .a0_valid(a0_valid), .a0_last(a0_last), .a0_ready(b0_ready),
    .a1_data(a1_data), .a1_valid(a1_valid), .a1_last(a1_last), .a1_ready(b1_ready),
    .y_data(y1_data), .y_valid(y1_valid), .y_last(y1_last), .y_src(y1_src), .y_ready(y_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner    = -1;
    prev_src = 1;
    mvalid   = 1'b0;
    sb.delete();
  endtask

  // One clock of stimulus: drive inputs, check readies against the model, record any accepted beat.
  task automatic cyc(input bit v0, input bit l0, input logic [7:0] d0,
                     input bit v1, input bit l1, input logic [7:0] d1, input bit yr);
    int win;
    bit ld;
    bit lst;
    @(negedge clk);
    a0_valid = v0; a0_last = l0; a0_data = d0;
    a1_valid = v1; a1_last = l1; a1_data = d1;
    y_ready  = yr;
    #1;
    chk("y_valid", y_valid, mvalid);
    ld = !mvalid || yr;
    if (owner >= 0)    win = owner;
    else if (v0 && v1) win = 1 - prev_src;
    else if (v0)       win = 0;
    else if (v1)       win = 1;
    else               win = -1;
    if (win >= 0 || !ld)
      chk("ready", {a1_ready, a0_ready}, {ld && (win == 1), ld && (win == 0)});
    else
      chk("ready_onehot", a0_ready & a1_ready, 0);
    if (ld && win >= 0 && ((win == 0) ? v0 : v1)) begin
      lst = (win == 0) ? l0 : l1;
      sb.push_back({(win == 0) ? d0 : d1, lst, win[0]});
      prev_src = win;
      mvalid   = 1'b1;
      if (owner < 0 && !lst)       owner = win;
      else if (owner == win && lst) owner = -1;
    end else if (ld) begin
      mvalid = 1'b0;
    end
  endtask

  // Asynchronous reset pulse between edges; outputs must clear immediately.
  task automatic pulse_rst(input int n);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_y_valid", y_valid, 0);
    chk("rst_ready", {a1_ready, a0_ready}, 0);
    chk("rst_y_fields", {y_data, y_last, y_src}, 0);
    model_reset();
    a0_valid = 1'b0;
    a1_valid = 1'b0;
    repeat (n) @(negedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks stability under stall.
  initial begin
    bit    stall;
    beat_t prev;
    beat_t e;
    stall = 1'b0;
    prev  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) chk("stall_hold", {y_valid, y_data, y_last, y_src}, {1'b1, prev});
        if (y_valid && y_ready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL out_unexpected actual=%0h expected=none at %0t", y_data, $time);
          end else begin
            e = sb.pop_front();
            chk("out_beat", {y_data, y_last, y_src}, e);
          end
        end
        stall = y_valid && !y_ready;
        prev  = {y_data, y_last, y_src};
      end
    end
  end

  initial begin
    model_reset();
    rst_n    = 1'b0;
    a0_valid = 1'b1; a0_last = 1'b1; a0_data = 8'h00;
    a1_valid = 1'b1; a1_last = 1'b1; a1_data = 8'h00;
    y_ready  = 1'b1;
    #12;
    chk("init_y", {y_valid, y_data, y_last, y_src}, 0);
    chk("init_ready", {a1_ready, a0_ready, b1_ready, b0_ready}, 0);
    a0_valid = 1'b0;
    a1_valid = 1'b0;
    @(negedge clk);
    #3;
    rst_n = 1'b1;

    // Both channels with single-beat packets: round-robin 0,1,0,1.
    repeat (4) cyc(1, 1, 8'($urandom), 1, 1, 8'($urandom), 1);

    // Three-beat packet from channel 0 while channel 1 waits.
    cyc(1, 0, 8'h11, 1, 1, 8'hA1, 1);
    cyc(1, 0, 8'h22, 1, 1, 8'hA2, 1);
    cyc(1, 1, 8'h33, 1, 1, 8'hA3, 1);
    cyc(0, 0, 8'h00, 1, 1, 8'hA4, 1);
    cyc(0, 0, 8'h00, 0, 0, 8'h00, 1);

    // Output stall for four cycles with 0x5A held.
    cyc(1, 1, 8'h5A, 0, 0, 8'h00, 1);
    repeat (4) cyc(1, 1, 8'h66, 1, 1, 8'h77, 0);
    cyc(1, 1, 8'h66, 1, 1, 8'h77, 1);
    cyc(0, 0, 8'h00, 0, 0, 8'h00, 1);

    // Lock on channel 1, owner drops valid while channel 0 requests.
    cyc(0, 0, 8'h00, 1, 0, 8'hB1, 1);
    repeat (3) cyc(1, 1, 8'hC0, 0, 0, 8'h00, 1);
    cyc(1, 1, 8'hC1, 1, 1, 8'hB2, 1);
    cyc(1, 1, 8'hC2, 0, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 0, 0, 8'h00, 1);

    // Reset while locked on channel 0 with an output beat held.
    cyc(1, 0, 8'hD1, 0, 0, 8'h00, 1);
    pulse_rst(2);

    // Streaming with last=0: locked instance stays on 0, unlocked instance alternates.
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 8'(8'hE0 + i), 1, 0, 8'(8'hF0 + i), 1);
      if (i >= 1) begin
        chk("nolock_valid", y1_valid, 1);
        chk("nolock_src", y1_src, (i - 1) % 2);
      end
    end
    cyc(1, 1, 8'hEF, 1, 0, 8'hFF, 1);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 8'($urandom),
          $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 8'($urandom),
          $urandom_range(0, 3) != 0);
      if (i == 1500) pulse_rst(1);
    end

    // Drain and confirm every predicted beat came out.
    repeat (4) cyc(0, 0, 8'h00, 0, 0, 8'h00, 1);
    chk("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
